alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that time-shares one combinational `alu` instance between up to four requesters in the RV32IM core, e.g. the execute-stage integer path and the multiply/divide or address-generation sequencers. It sits in the execute stage between the requesters and the ALU. It drives the ALU operand and opcode inputs from the granted request and captures the ALU result, zero flag and overflow flag into a single response register. It returns that registered response to the owning requester over a valid/ready handshake.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters. Legal range 2..4.
- `XLEN`, from `riscv_core_pkg`: data width, 32.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `flush_i`  in  1  synchronous pipeline flush.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester grant/accept.
- `req_op_i`  in  NUM_REQ x alu_op_e  per-requester opcode.
- `req_a_i`, `req_b_i`  in  NUM_REQ x XLEN  per-requester operands.
- `rsp_valid_o`  out  NUM_REQ  response valid. One-hot: only the owner's bit is set.
- `rsp_ready_i`  in  NUM_REQ  per-requester response ready.
- `rsp_result_o`  out  XLEN  registered ALU result, shared bus.
- `rsp_zero_o`, `rsp_overflow_o`  out  1  registered ALU flags.
- `alu_op_o`, `alu_a_o`, `alu_b_o`  out  alu_op_e/XLEN/XLEN  drive the ALU.
- `alu_result_i`, `alu_zero_i`, `alu_overflow_i`  in  XLEN/1/1  ALU outputs.

## Operation
State:
- `rr_ptr`, log2(NUM_REQ) bits: requester with highest priority.
- Response register: `rsp_full`, `rsp_owner`, result, zero, overflow.

Accept rule:
- `can_accept = !flush_i && (!rsp_full || rsp_ready_i[rsp_owner])`. This allows drain and refill in the same cycle.

Grant:
- Scan `req_valid_i` starting at `rr_ptr` and wrapping modulo NUM_REQ.
- The first valid index g gets `req_ready_o[g] = can_accept`. All other ready bits are 0.
- At most one ready bit is high per cycle.

ALU drive:
- `alu_*_o` take request g's fields whenever any request is valid, otherwise all zeros with `ALU_OP_ADD`.
- Drive is purely combinational; no ALU output is stored before acceptance.

On accept (`req_valid_i[g] && req_ready_o[g]`):
- Capture `alu_result_i`, `alu_zero_i` and `alu_overflow_i`.
- Set `rsp_owner = g` and `rsp_full = 1`.
- Set `rr_ptr = (g+1) mod NUM_REQ`.
- `rr_ptr` changes only on an accept.

Drain:
- When `rsp_ready_i[rsp_owner]` is high and there is no new accept, clear `rsp_full`.
- `rsp_valid_o = rsp_full ? onehot(rsp_owner) : 0`.
- Response data is held stable while valid and not ready.

Flush:
- Clear `rsp_full` and block any grant that cycle.
- `rr_ptr` is unchanged.
- Flush takes priority over drain and accept in the same cycle.

Handshake contract:
- `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not derive valid from ready.
- Once asserted, a request stays valid with stable fields until accepted or flushed by its owner.

Invalid opcodes pass through unchanged. Capturing X from the ALU is the requester's responsibility.

## Timing
- Reset (async assert, sync deassert handled upstream): `rr_ptr = 0`, `rsp_full = 0`, result/flags = 0, `rsp_owner = 0`.
- Under reset all `req_ready_o` and `rsp_valid_o` are 0.
- Latency: accept in cycle N gives `rsp_valid_o` in cycle N+1.
- Throughput: one accept per cycle while the owner of the held response is ready, or the register is empty.
- Backpressure: if the owner holds `rsp_ready_i` low, no requester is granted. This stalls all requesters.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Wrap-around: `rr_ptr` at NUM_REQ-1 followed by a grant to index NUM_REQ-1 returns to 0.
- Simultaneous drain+accept: the new response replaces the old in the same edge and `rsp_valid_o` stays high with the new owner.
- Reset mid-operation discards the held response immediately, with no response issued.

## Test plan
- Single request: req0 ADD a=5 b=7 with all others idle → `req_ready_o=01`; next cycle `rsp_valid_o=01`, result=12, zero=0, overflow=0.
- Contention: req0 and req1 both valid continuously, consumers always ready → grants alternate 0,1,0,1 and `rsp_owner` alternates the same way, one response per cycle.
- Backpressure: req0 SUB 3-3 held with `rsp_ready_i[0]=0` for 4 cycles while req1 is valid → req1 is not granted, result=0 and zero=1 are held stable; req1 is granted in the cycle `rsp_ready_i[0]` rises.
- Overflow: ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1. SUB 0x80000000-1 → overflow=1.
- Flush: flush with a response held and req1 valid → next cycle `rsp_valid_o=0`, no accept that cycle, `rr_ptr` unchanged.
- Async reset asserted mid-burst (NUM_REQ=4) → outputs go to 0 without waiting for a clock edge; after release the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// The ALU result is held in a single response register returned to its owner.
package riscv_core_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR,
    ALU_OP_SLL,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_SLT,
    ALU_OP_SLTU
  } alu_op_e;
endpackage

module alu_share_arbiter
  import riscv_core_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  alu_op_e [NUM_REQ-1:0]          req_op_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [XLEN-1:0]                rsp_result_o,
  output logic                           rsp_zero_o,
  output logic                           rsp_overflow_o,
  output alu_op_e                        alu_op_o,
  output logic [XLEN-1:0]                alu_a_o,
  output logic [XLEN-1:0]                alu_b_o,
  input  logic [XLEN-1:0]                alu_result_i,
  input  logic                           alu_zero_i,
  input  logic                           alu_overflow_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rsp_full_q, rsp_full_d;
  logic [PW-1:0]   rsp_owner_q, rsp_owner_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_ovf_q, rsp_ovf_d;

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  int            sum;
  int            nxt;
  logic          can_accept;
  logic          accept;
  logic          drain;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    sum     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(rr_ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = PW'(sum);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Reset gates ready so nothing is granted while rst_ni is low.
  assign can_accept = rst_ni && !flush_i &&
                      (!rsp_full_q || rsp_ready_i[rsp_owner_q]);
  assign accept = gnt_vld && can_accept;
  assign drain  = rsp_full_q && rsp_ready_i[rsp_owner_q] &&
                  !accept && !flush_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_full_q) rsp_valid_o[rsp_owner_q] = 1'b1;
  end

  always_comb begin
    alu_op_o = ALU_OP_ADD;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (gnt_vld) begin
      alu_op_o = req_op_i[gnt_idx];
      alu_a_o  = req_a_i[gnt_idx];
      alu_b_o  = req_b_i[gnt_idx];
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rsp_full_d   = rsp_full_q;
    rsp_owner_d  = rsp_owner_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    nxt          = int'(gnt_idx) + 1;
    unique case (1'b1)
      flush_i: begin
        rsp_full_d = 1'b0;
      end
      accept: begin
        rsp_full_d   = 1'b1;
        rsp_owner_d  = gnt_idx;
        rsp_result_d = alu_result_i;
        rsp_zero_d   = alu_zero_i;
        rsp_ovf_d    = alu_overflow_i;
        rr_ptr_d     = (nxt >= NUM_REQ) ? '0 : PW'(nxt);
      end
      drain: begin
        rsp_full_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      rsp_full_q   <= 1'b0;
      rsp_owner_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_full_q   <= rsp_full_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_result_o   = rsp_result_q;
  assign rsp_zero_o     = rsp_zero_q;
  assign rsp_overflow_o = rsp_ovf_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboarded random bench for alu_share_arbiter with four requesters.
// A behavioural ALU stands in for the shared ALU instance.
module tb_alu_share_arbiter;
  import riscv_core_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  alu_op_e [N-1:0] req_op;
  logic [N-1:0][31:0] req_a;
  logic [N-1:0][31:0] req_b;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready = '1;
  logic [31:0] rsp_result;
  logic rsp_zero, rsp_ovf;
  alu_op_e alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic alu_z, alu_ov;

  typedef struct {
    int own;
    logic [31:0] r;
    logic z;
    logic o;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int mptr = 0;
  int mown = 0;
  bit mfull = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
    .rsp_overflow_o(rsp_ovf),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_res), .alu_zero_i(alu_z),
    .alu_overflow_i(alu_ov)
  );

  function automatic logic [33:0] alu_ref(
    input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    longint maxv;
    longint minv;
    logic [31:0] r;
    logic o;
    maxv = 64'sh7FFFFFFF;
    minv = -64'sh80000000;
    r = '0;
    o = 1'b0;
    s = 0;
    case (op)
      ALU_OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        o = (s > maxv) || (s < minv);
      end
      ALU_OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        o = (s > maxv) || (s < minv);
      end
      ALU_OP_AND:  r = a & b;
      ALU_OP_OR:   r = a | b;
      ALU_OP_XOR:  r = a ^ b;
      ALU_OP_SLL:  r = a << b[4:0];
      ALU_OP_SRL:  r = a >> b[4:0];
      ALU_OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: r = {31'b0, a < b};
      default:     r = '0;
    endcase
    return {r, (r == 32'd0), o};
  endfunction

  always_comb {alu_res, alu_z, alu_ov} = alu_ref(alu_op, alu_a, alu_b);

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && !flush && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: rsp_valid=%b expected none", rsp_valid);
      end else begin
        check("rsp_owner", 64'(rsp_valid), 64'(4'b0001 << sb[0].own));
        check("rsp_result", 64'(rsp_result), 64'(sb[0].r));
        check("rsp_zero", 64'(rsp_zero), 64'(sb[0].z));
        check("rsp_overflow", 64'(rsp_ovf), 64'(sb[0].o));
        if ((rsp_valid & rsp_ready) != '0) void'(sb.pop_front());
      end
    end
  end

  task automatic set_req(input int i, input alu_op_e op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_op[i] = op;
    req_a[i] = a;
    req_b[i] = b;
  endtask

  task automatic step();
    int g;
    bit can;
    logic [N-1:0] exp_vld;
    logic [N-1:0] exp_rdy;
    logic [33:0] rr;
    exp_t e;
    @(negedge clk);
    exp_vld = mfull ? 4'(4'b0001 << mown) : '0;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
    g = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (mptr + i) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    can = !flush && (!mfull || rsp_ready[mown]);
    exp_rdy = (g >= 0 && can) ? 4'(4'b0001 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (flush) begin
      if (mfull) void'(sb.pop_front());
      mfull = 1'b0;
    end else if (g >= 0 && can) begin
      rr = alu_ref(req_op[g], req_a[g], req_b[g]);
      e.own = g;
      e.r = rr[33:2];
      e.z = rr[1];
      e.o = rr[0];
      sb.push_back(e);
      mfull = 1'b1;
      mown = g;
      mptr = (g + 1) % N;
    end else if (mfull && rsp_ready[mown]) begin
      mfull = 1'b0;
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~exp_rdy;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_setup();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(0, 2) == 0)
        set_req(i, alu_op_e'($urandom_range(0, 9)), rnd(), rnd());
      rsp_ready[i] = ($urandom_range(0, 3) != 0);
    end
    flush = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    req_op = '{default: ALU_OP_ADD};
    req_a = '0;
    req_b = '0;
    set_req(0, ALU_OP_ADD, 32'd5, 32'd7);
    #1;
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_valid", 64'(rsp_valid), 64'(0));
    check("reset_result", 64'(rsp_result), 64'(0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    step();
    check("single_valid", 64'(rsp_valid), 64'(4'b0001));
    check("single_result", 64'(rsp_result), 64'(32'd12));
    check("single_flags", 64'({rsp_zero, rsp_ovf}), 64'(0));
    step();

    for (int k = 0; k < 4; k++) begin
      set_req(0, ALU_OP_ADD, 32'd10, 32'd20);
      set_req(1, ALU_OP_XOR, 32'hF0F0, 32'h0FF0);
      step();
    end
    req_valid = '0;
    step();
    step();

    rsp_ready = '0;
    set_req(0, ALU_OP_SUB, 32'd3, 32'd3);
    step();
    set_req(1, ALU_OP_ADD, 32'd1, 32'd2);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_result", 64'(rsp_result), 64'(0));
      check("bp_zero", 64'(rsp_zero), 64'(1));
    end
    rsp_ready = '1;
    step();
    step();

    set_req(2, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1);
    step();
    check("ovf_add_result", 64'(rsp_result), 64'(32'h8000_0000));
    check("ovf_add_flag", 64'(rsp_ovf), 64'(1));
    set_req(3, ALU_OP_SUB, 32'h8000_0000, 32'd1);
    step();
    check("ovf_sub_flag", 64'(rsp_ovf), 64'(1));
    step();

    rsp_ready = '0;
    set_req(0, ALU_OP_ADD, 32'd1, 32'd1);
    step();
    set_req(1, ALU_OP_OR, 32'h3, 32'h4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(rsp_valid), 64'(0));
    step();
    rsp_ready = '1;
    step();

    for (int i = 0; i < N; i++)
      set_req(i, ALU_OP_AND, 32'($urandom()), 32'($urandom()));
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < N; i++)
      if (!req_valid[i]) set_req(i, ALU_OP_SLT, rnd(), rnd());
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_ready", 64'(req_ready), 64'(0));
    check("rst_mid_valid", 64'(rsp_valid), 64'(0));
    check("rst_mid_result", 64'(rsp_result), 64'(0));
    mptr = 0;
    mfull = 1'b0;
    mown = 0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req_valid = 4'b1100;
    step();
    step();

    for (int k = 0; k < 400; k++) begin
      rand_setup();
      step();
    end

    flush = 1'b0;
    rsp_ready = '1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
